// File: rtl/helper_nvm_pkg.sv
// Shared types and constants for the helper-data NVM writer.
// crc16_step folds one 16-bit half-word into a CRC-16-CCITT, MSB first.
package helper_nvm_pkg;

  localparam int unsigned HELPER_HALFWORDS = 44;
  localparam logic [15:0] CRC16_POLY       = 16'h1021;
  localparam logic [15:0] CRC16_INIT       = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DRAIN,
    CRC_WR,
    DONE
  } state_e;

  // Data is XORed into the register up front; with 16-bit data and a 16-bit CRC
  // this matches feeding the data bits one at a time.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/helper_nvm_fifo.sv
// Synchronous FIFO with asynchronous reset; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module helper_nvm_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/helper_data_nvm_writer.sv
// Packs 16-bit helper-data half-words into 32-bit words, buffers them and writes
// them to NVM over req/ack. Define HELPER_NVM_CRC_EN to append a CRC-16 word.
module helper_data_nvm_writer
  import helper_nvm_pkg::*;
#(
  parameter int unsigned HALFWORDS  = HELPER_HALFWORDS,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in_word,
  input  logic              in_valid,
  input  logic              in_done,
  output logic              nvm_wr_req,
  output logic [ADDR_W-1:0] nvm_addr,
  output logic [31:0]       nvm_wdata,
  input  logic              nvm_wr_ack,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic              len_err
);

  state_e            state_q, state_d;
  logic              in_done_q;
  logic [6:0]        cnt_q, cnt_d;
  logic [15:0]       low_q, low_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ovf_q, ovf_d;
  logic              len_q, len_d;
`ifdef HELPER_NVM_CRC_EN
  logic [15:0]       crc_q, crc_d;
`endif

  logic        done_edge, start, accept;
  logic [6:0]  cnt_base;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;

  assign done_edge = in_done & ~in_done_q;

  helper_nvm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (fifo_push),
    .wdata_i ({in_word, low_q}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    low_d     = low_q;
    widx_d    = widx_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ovf_d     = ovf_q;
    len_d     = len_q;
`ifdef HELPER_NVM_CRC_EN
    crc_d     = crc_q;
`endif
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    start     = in_valid && (state_q == IDLE || state_q == DONE);
    accept    = start || (in_valid && state_q == COLLECT);
    cnt_base  = start ? '0 : cnt_q;

    if (start) begin
      ovf_d  = 1'b0;
      len_d  = 1'b0;
      widx_d = '0;
    end

    // A new record restarts the count, so parity comes from cnt_base, not cnt_q.
    if (accept) begin
      if (cnt_base[0]) begin
        fifo_push = 1'b1;
        if (fifo_full) ovf_d = 1'b1;
      end else begin
        low_d = in_word;
      end
      cnt_d = (cnt_base == 7'd127) ? cnt_base : cnt_base + 7'd1;
`ifdef HELPER_NVM_CRC_EN
      crc_d = crc16_step(start ? CRC16_INIT : crc_q, in_word);
`endif
    end

    if (state_q == COLLECT || state_q == DRAIN) begin
      if (req_q) begin
        if (nvm_wr_ack) begin
          req_d    = 1'b0;
          fifo_pop = 1'b1;
          widx_d   = widx_q + ADDR_W'(1);
        end
      end else if (!fifo_empty) begin
        req_d   = 1'b1;
        addr_d  = ADDR_W'(BASE_ADDR) + widx_q;
        wdata_d = fifo_rdata;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (in_valid) state_d = COLLECT;
      end
      COLLECT: begin
        if (done_edge) begin
          state_d = DRAIN;
          if (cnt_d != 7'(HALFWORDS)) len_d = 1'b1;
        end
      end
      DRAIN: begin
        if (fifo_empty && !req_q) begin
`ifdef HELPER_NVM_CRC_EN
          if (!len_q) begin
            state_d = CRC_WR;
            req_d   = 1'b1;
            addr_d  = ADDR_W'(BASE_ADDR + HALFWORDS / 2);
            wdata_d = {16'h0000, crc_q};
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
`ifdef HELPER_NVM_CRC_EN
      CRC_WR: begin
        if (nvm_wr_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      in_done_q <= 1'b0;
      cnt_q     <= '0;
      low_q     <= '0;
      widx_q    <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ovf_q     <= 1'b0;
      len_q     <= 1'b0;
`ifdef HELPER_NVM_CRC_EN
      crc_q     <= CRC16_INIT;
`endif
    end else begin
      state_q   <= state_d;
      in_done_q <= in_done;
      cnt_q     <= cnt_d;
      low_q     <= low_d;
      widx_q    <= widx_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ovf_q     <= ovf_d;
      len_q     <= len_d;
`ifdef HELPER_NVM_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign nvm_wr_req   = req_q;
  assign nvm_addr     = addr_q;
  assign nvm_wdata    = wdata_q;
  assign busy         = (state_q == COLLECT) || (state_q == DRAIN) || (state_q == CRC_WR);
  assign done         = (state_q == DONE);
  assign overflow_err = ovf_q;
  assign len_err      = len_q;

endmodule

// File: tb/tb_helper_data_nvm_writer.sv
// Bench for helper_data_nvm_writer: a default instance plus a FIFO_DEPTH=4
// instance for overflow, both fed the same half-word stream.
module tb_helper_data_nvm_writer;

`ifdef HELPER_NVM_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  localparam int HW = 44;

  logic clk = 1'b0;
  logic reset, in_valid, in_done;
  logic [15:0] in_word;
  logic reqA, ackA, busyA, doneA, ovfA, lenA;
  logic reqB, ackB, busyB, doneB, ovfB, lenB;
  logic [9:0]  addrA, addrB;
  logic [31:0] dataA, dataB;

  always #5 clk = ~clk;

  helper_data_nvm_writer dut (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .in_done(in_done),
    .nvm_wr_req(reqA), .nvm_addr(addrA), .nvm_wdata(dataA), .nvm_wr_ack(ackA),
    .busy(busyA), .done(doneA), .overflow_err(ovfA), .len_err(lenA)
  );

  helper_data_nvm_writer #(.FIFO_DEPTH(4)) dut_ovf (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .in_done(in_done),
    .nvm_wr_req(reqB), .nvm_addr(addrB), .nvm_wdata(dataB), .nvm_wr_ack(ackB),
    .busy(busyB), .done(doneB), .overflow_err(ovfB), .len_err(lenB)
  );

  int total = 0;
  int passed = 0;
  logic [15:0] hw [64];
  int delay_a = 0;
  bit spur_a = 1'b0;
  bit hold_b = 1'b0;
  int stab_err_a = 0;
  logic [9:0]  wa_addr[$], wb_addr[$], exp_addr[$];
  logic [31:0] wa_data[$], wb_data[$], exp_data[$];

  // NVM model for the default instance: ack after delay_a waiting cycles,
  // optional random acks while idle, and a hold-stable check while req is high.
  initial begin : resp_a
    int w;
    logic prev;
    logic [9:0] a0;
    logic [31:0] d0;
    ackA = 1'b0; w = 0; prev = 1'b0; a0 = '0; d0 = '0;
    forever begin
      @(negedge clk);
      ackA = 1'b0;
      if (reset) begin
        w = 0; prev = 1'b0;
      end else if (reqA) begin
        if (!prev) begin a0 = addrA; d0 = dataA; end
        else if (addrA !== a0 || dataA !== d0) stab_err_a++;
        if (w >= delay_a) begin
          ackA = 1'b1; w = 0;
          wa_addr.push_back(addrA); wa_data.push_back(dataA);
        end else w++;
        prev = 1'b1;
      end else begin
        w = 0; prev = 1'b0;
        if (spur_a) ackA = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : resp_b
    ackB = 1'b0;
    forever begin
      @(negedge clk);
      ackB = 1'b0;
      if (!reset && reqB && !hold_b) begin
        ackB = 1'b1;
        wb_addr.push_back(addrB); wb_data.push_back(dataB);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: CRC-16-CCITT computed one message bit at a time.
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ hw[i][b];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  // Expected write list: complete pairs in order (at most keep of them), then the
  // CRC word at HW/2 when the record length was exact.
  function automatic void build_exp(input int n_hw, input int keep);
    exp_addr.delete(); exp_data.delete();
    for (int i = 0; i < n_hw / 2 && i < keep; i++) begin
      exp_addr.push_back(10'(i));
      exp_data.push_back({hw[2*i+1], hw[2*i]});
    end
    if (CRC_EN && n_hw == HW) begin
      exp_addr.push_back(10'(HW / 2));
      exp_data.push_back({16'h0000, ref_crc(n_hw)});
    end
  endfunction

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; in_done = 1'b0; in_word = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
  endtask

  task automatic send_record(input int first, input int n, input int maxgap, input bit with_done);
    for (int i = first; i < n; i++) begin
      in_word = hw[i]; in_valid = 1'b1;
      if (with_done && i == n - 1) in_done = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    end
    in_done = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_done = 1'b0;
  endtask

  task automatic wait_done(input bit which, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if ((which ? doneB : doneA) === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({reqA, addrA, dataA, busyA, doneA, ovfA, lenA} !== '0)
      $display("FAIL reset_a got req=%b addr=%0h data=%08h busy=%b done=%b ovf=%b len=%b want all 0", reqA, addrA, dataA, busyA, doneA, ovfA, lenA);
    else passed++;
    total++;
    if ({reqB, addrB, dataB, busyB, doneB, ovfB, lenB} !== '0)
      $display("FAIL reset_b got req=%b addr=%0h data=%08h want all 0", reqB, addrB, dataB);
    else passed++;
  endtask

  task automatic test_normal();
    bit ok;
    for (int i = 0; i < HW; i++) hw[i] = 16'(i);
    delay_a = 0;
    wa_addr.delete(); wa_data.delete();
    in_word = hw[0]; in_valid = 1'b1; @(posedge clk); #1;
    in_word = hw[1]; @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (reqA !== 1'b0) $display("FAIL norm_lat1 got req=%b want 0", reqA); else passed++;
    @(posedge clk); #1;
    total++;
    if ({reqA, busyA, addrA, dataA} !== {2'b11, 10'd0, 32'h0001_0000})
      $display("FAIL norm_lat2 got req=%b busy=%b addr=%0h data=%08h want req=1 busy=1 addr=0 data=00010000", reqA, busyA, addrA, dataA);
    else passed++;
    send_record(2, HW, 0, 1'b0);
    wait_done(1'b0, ok);
    total++;
    if (!ok) $display("FAIL norm_done_wait got done=%b want 1", doneA); else passed++;
    build_exp(HW, 99);
    total++;
    if (wa_addr.size() != exp_addr.size()) $display("FAIL norm_count got %0d want %0d", wa_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size() && i < wa_addr.size(); i++) begin
      total++;
      if ({wa_addr[i], wa_data[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL norm_wr[%0d] got addr=%0h data=%08h want addr=%0h data=%08h", i, wa_addr[i], wa_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    total++;
    if ({doneA, busyA, ovfA, lenA, reqA} !== 5'b10000)
      $display("FAIL norm_status got done=%b busy=%b ovf=%b len=%b req=%b want 1 0 0 0 0", doneA, busyA, ovfA, lenA, reqA);
    else passed++;
  endtask

  task automatic test_slow();
    bit ok;
    for (int i = 0; i < HW; i++) hw[i] = 16'($urandom);
    delay_a = 5; spur_a = 1'b1; stab_err_a = 0;
    wa_addr.delete(); wa_data.delete();
    send_record(0, HW, 3, 1'b0);
    wait_done(1'b0, ok);
    total++;
    if (!ok) $display("FAIL slow_done_wait got done=%b want 1", doneA); else passed++;
    build_exp(HW, 99);
    total++;
    if (wa_addr.size() != exp_addr.size()) $display("FAIL slow_count got %0d want %0d", wa_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size() && i < wa_addr.size(); i++) begin
      total++;
      if ({wa_addr[i], wa_data[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL slow_wr[%0d] got addr=%0h data=%08h want addr=%0h data=%08h", i, wa_addr[i], wa_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    total++;
    if (stab_err_a != 0) $display("FAIL slow_stable got %0d unstable cycles want 0", stab_err_a); else passed++;
    total++;
    if ({doneA, busyA, ovfA, lenA} !== 4'b1000)
      $display("FAIL slow_status got done=%b busy=%b ovf=%b len=%b want 1 0 0 0", doneA, busyA, ovfA, lenA);
    else passed++;
    delay_a = 0; spur_a = 1'b0;
  endtask

  task automatic test_overflow();
    bit ok;
    apply_reset();
    for (int i = 0; i < HW; i++) hw[i] = 16'($urandom);
    hold_b = 1'b1;
    for (int i = 0; i < HW; i++) begin
      in_word = hw[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 7) begin
        total++;
        if (ovfB !== 1'b0) $display("FAIL ovf_4th_push got ovf=%b want 0", ovfB); else passed++;
      end
      if (i == 9) begin
        total++;
        if (ovfB !== 1'b1) $display("FAIL ovf_5th_push got ovf=%b want 1", ovfB); else passed++;
      end
    end
    in_valid = 1'b0; in_done = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    in_done = 1'b0;
    total++;
    if ({reqB, addrB, dataB} !== {1'b1, 10'd0, hw[1], hw[0]})
      $display("FAIL ovf_held got req=%b addr=%0h data=%08h want req=1 addr=0 data=%04h%04h", reqB, addrB, dataB, hw[1], hw[0]);
    else passed++;
    hold_b = 1'b0;
    wait_done(1'b1, ok);
    total++;
    if (!ok) $display("FAIL ovf_done_wait got done=%b want 1", doneB); else passed++;
    build_exp(HW, 4);
    total++;
    if (wb_addr.size() != exp_addr.size()) $display("FAIL ovf_count got %0d want %0d", wb_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size() && i < wb_addr.size(); i++) begin
      total++;
      if ({wb_addr[i], wb_data[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL ovf_wr[%0d] got addr=%0h data=%08h want addr=%0h data=%08h", i, wb_addr[i], wb_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    total++;
    if ({doneB, busyB, ovfB, lenB} !== 4'b1010)
      $display("FAIL ovf_status got done=%b busy=%b ovf=%b len=%b want 1 0 1 0", doneB, busyB, ovfB, lenB);
    else passed++;
  endtask

  task automatic test_short();
    bit ok;
    for (int i = 0; i < HW; i++) hw[i] = 16'($urandom);
    wa_addr.delete(); wa_data.delete();
    send_record(0, HW - 1, 1, 1'b0);
    wait_done(1'b0, ok);
    total++;
    if (!ok) $display("FAIL short_done_wait got done=%b want 1", doneA); else passed++;
    build_exp(HW - 1, 99);
    total++;
    if (wa_addr.size() != exp_addr.size()) $display("FAIL short_count got %0d want %0d", wa_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size() && i < wa_addr.size(); i++) begin
      total++;
      if ({wa_addr[i], wa_data[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL short_wr[%0d] got addr=%0h data=%08h want addr=%0h data=%08h", i, wa_addr[i], wa_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    total++;
    if ({doneA, busyA, ovfA, lenA} !== 4'b1001)
      $display("FAIL short_status got done=%b busy=%b ovf=%b len=%b want 1 0 0 1", doneA, busyA, ovfA, lenA);
    else passed++;
    wa_addr.delete(); wa_data.delete();
    in_done = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_done = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    total++;
    if ({doneA, busyA, reqA, lenA} !== 4'b1001 || wa_addr.size() != 0)
      $display("FAIL short_extra_edge got done=%b busy=%b req=%b len=%b writes=%0d want 1 0 0 1 0", doneA, busyA, reqA, lenA, wa_addr.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < HW; i++) hw[i] = 16'($urandom);
    wa_addr.delete(); wa_data.delete();
    in_word = hw[0]; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({doneA, lenA, busyA} !== 3'b001)
      $display("FAIL b2b_clear got done=%b len=%b busy=%b want 0 0 1", doneA, lenA, busyA);
    else passed++;
    send_record(1, HW, 1, 1'b1);
    wait_done(1'b0, ok);
    total++;
    if (!ok) $display("FAIL b2b_done_wait got done=%b want 1", doneA); else passed++;
    build_exp(HW, 99);
    total++;
    if (wa_addr.size() != exp_addr.size()) $display("FAIL b2b_count got %0d want %0d", wa_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size() && i < wa_addr.size(); i++) begin
      total++;
      if ({wa_addr[i], wa_data[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL b2b_wr[%0d] got addr=%0h data=%08h want addr=%0h data=%08h", i, wa_addr[i], wa_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    total++;
    if ({doneA, busyA, ovfA, lenA} !== 4'b1000)
      $display("FAIL b2b_status got done=%b busy=%b ovf=%b len=%b want 1 0 0 0", doneA, busyA, ovfA, lenA);
    else passed++;
  endtask

  task automatic test_reset_midwrite();
    bit ok;
    for (int i = 0; i < HW; i++) hw[i] = 16'($urandom);
    delay_a = 5;
    for (int i = 0; i < 6; i++) begin
      in_word = hw[i]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (reqA === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!ok) $display("FAIL rst_mid_req got req=%b want 1 before reset", reqA); else passed++;
    #1 reset = 1'b1;
    #1;
    total++;
    if ({reqA, addrA, dataA, busyA, doneA, ovfA, lenA} !== '0)
      $display("FAIL rst_mid_async got req=%b addr=%0h data=%08h busy=%b done=%b want all 0", reqA, addrA, dataA, busyA, doneA);
    else passed++;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0; delay_a = 0;
    wa_addr.delete(); wa_data.delete();
    for (int i = 0; i < HW; i++) hw[i] = 16'(i);
    send_record(0, HW, 0, 1'b0);
    wait_done(1'b0, ok);
    total++;
    if (!ok) $display("FAIL rst_rec_done_wait got done=%b want 1", doneA); else passed++;
    build_exp(HW, 99);
    total++;
    if (wa_addr.size() != exp_addr.size()) $display("FAIL rst_rec_count got %0d want %0d", wa_addr.size(), exp_addr.size()); else passed++;
    for (int i = 0; i < exp_addr.size() && i < wa_addr.size(); i++) begin
      total++;
      if ({wa_addr[i], wa_data[i]} !== {exp_addr[i], exp_data[i]})
        $display("FAIL rst_rec_wr[%0d] got addr=%0h data=%08h want addr=%0h data=%08h", i, wa_addr[i], wa_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    total++;
    if ({doneA, busyA, ovfA, lenA} !== 4'b1000)
      $display("FAIL rst_rec_status got done=%b busy=%b ovf=%b len=%b want 1 0 0 0", doneA, busyA, ovfA, lenA);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_slow();
    test_overflow();
    test_short();
    test_back_to_back();
    test_reset_midwrite();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/helper_data_nvm_writer.md
Name: helper_data_nvm_writer

Overview:
- Downstream consumer of the key-generation system's 16-bit helper-data bus (44 half-words per 704-bit helper record, word 0 = bits [15:0]).
- Packs half-words into 32-bit words and buffers them, because the source has no backpressure.
- Writes the words to external non-volatile memory over a req/ack handshake.
- Optionally appends a CRC-16 integrity word for later reconstruction.

Parameters:
- HALFWORDS, 44, expected half-words per record (must be even).
- FIFO_DEPTH, 32, 32-bit buffer entries (power of two, >= HALFWORDS/2+1).
- ADDR_W, 10, NVM word-address width.
- BASE_ADDR, 0, NVM word address of the record's first word.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_word  in  16  helper-data half-word.
- in_valid  in  1  in_word valid this cycle; no backpressure.
- in_done  in  1  level from source; its rising edge marks end of record.
- nvm_wr_req  out  1  write request.
- nvm_addr  out  ADDR_W  word address.
- nvm_wdata  out  32  write data.
- nvm_wr_ack  in  1  one-cycle write acknowledge.
- busy  out  1  record in progress or buffer not drained.
- done  out  1  level: record fully written to NVM.
- overflow_err  out  1  sticky: a word was dropped on full FIFO.
- len_err  out  1  sticky: in_done edge arrived with half-word count != HALFWORDS.

Behaviour:
- Reset values: all outputs 0; FIFO empty; CRC = 0xFFFF; counters 0; state IDLE. Reset mid-write drops nvm_wr_req asynchronously, and no partial state survives.
- FSM states: IDLE, COLLECT, DRAIN, CRC_WR, DONE.
  - IDLE/DONE -> COLLECT on in_valid. The first half-word is accepted that cycle; done, overflow_err and len_err clear on that same edge.
  - COLLECT -> DRAIN on in_done rising edge (registered in_done, edge = in_done & ~in_done_q).
  - DRAIN -> CRC_WR when the FIFO is empty and no write is outstanding (CRC enabled), else -> DONE.
  - CRC_WR -> DONE on nvm_wr_ack.
- Packing:
  - Even half-word goes to a low holding register.
  - Odd half-word pushes {in_word, low} into the FIFO.
  - Half-word counter is 7 bits and saturates at 127.
- Simultaneous in_valid and in_done edge in one cycle: the word is accepted first, then the end of record is processed.
- End-of-record checks:
  - Count != HALFWORDS sets len_err.
  - An odd pending half-word is discarded.
  - The CRC word is suppressed; done still asserts.
- FIFO full on push: the word is dropped, overflow_err=1, and the record continues. Pushes beyond FIFO_DEPTH never corrupt existing entries.
- Write handshake:
  - nvm_wr_req rises the cycle after the FIFO is non-empty in COLLECT or DRAIN.
  - nvm_addr and nvm_wdata are held stable while req=1.
  - req drops on the cycle after ack is sampled, and the FIFO pops on that same edge.
  - The next req may rise no earlier than one cycle after it drops.
  - Any ack seen while req=0 is ignored.
- Address: BASE_ADDR + write index. The index is ADDR_W bits and wraps modulo 2^ADDR_W. Dropped words do not consume an index.
- Latency, zero-wait ack: first write request 2 cycles after the 2nd half-word.
- busy=1 in COLLECT, DRAIN and CRC_WR.
- done=1 from the DONE entry edge until the next record starts.
- A further in_done edge while in IDLE/DONE is ignored.

Optional Feature:
- Macro HELPER_NVM_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is updated MSB-first over every accepted half-word, including dropped ones.
  - On a clean end of record, {16'h0000, crc} is written at BASE_ADDR+HALFWORDS/2.
- Undefined: CRC logic and the CRC_WR state are absent; DRAIN -> DONE directly.

Decomposition:
- helper_nvm_pkg holds: HELPER_HALFWORDS=44, CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF, the state enum type, and the crc16_step function (16-bit data).
- One sub-module, helper_nvm_fifo: synchronous FIFO with async reset, 32-bit width, FIFO_DEPTH deep, full/empty/push/pop.

Test Plan:
- Normal record: 44 half-words 0x0000..0x002B with zero-wait ack -> 22 writes, addr 0..21, data 0x00010000, 0x00030002, ..., 0x002B002A. With CRC_EN, 23rd write at addr 22 equals the reference-model CRC in the low 16 bits. Then done=1, busy=0, no errors.
- Slow NVM: ack 5 cycles after each req, FIFO_DEPTH=32 -> all 22 words written in order, req/addr/data stable for the full wait, no overflow.
- Overflow: FIFO_DEPTH=4, ack held low for 30 cycles -> overflow_err=1 on the 5th push; after release, only words 0..3 plus any later pushes that fit are written, and their addresses stay contiguous.
- Short record: in_done edge after 43 half-words -> len_err=1, 21 words written, odd half-word discarded, no CRC write, done=1.
- Reset mid-write: reset asserted while req=1 -> req=0 asynchronously, all outputs 0. A following full record behaves exactly as in the normal-record scenario, starting at addr 0.
- Back-to-back records: second record starts while done=1 -> done and errors clear on the first accepted half-word, and the second record is written again from BASE_ADDR.
